wb_tag_pipe: RTL and testbench

WB_TAG_PIPE -- requirements
Module: wb_tag_pipe

---
 rtl/wb_tag_pkg.sv | 15 +
 rtl/reg_pending_cnt.sv | 49 ++++
 rtl/wb_tag_pipe.sv | 85 ++++++++
 tb/tb_wb_tag_pipe.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_tag_pkg.sv
// Shared types for the write-back tag pipeline: the per-stage tag and its bubble value.
package wb_tag_pkg;

    localparam int REG_AW = 5;
    localparam int NREGS  = 1 << REG_AW;

    typedef struct packed {
        logic              regwr;
        logic              memread;
        logic [REG_AW-1:0] dst;
    } tag_t;

    localparam tag_t BUBBLE_TAG = '{regwr: 1'b0, memread: 1'b0, dst: '0};

endpackage

// File: rtl/reg_pending_cnt.sv
// Per-register in-flight write counters; pending[r] flags registers with a write still in the pipe.
module reg_pending_cnt
    import wb_tag_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_en,
    input  logic              i_inc,
    input  logic [REG_AW-1:0] i_inc_addr,
    input  logic              i_dec,
    input  logic [REG_AW-1:0] i_dec_addr,
    output logic [NREGS-1:0]  o_pending
);

    logic [CNT_W-1:0] r_cnt [NREGS];
    logic [NREGS-1:0] w_inc_hit;
    logic [NREGS-1:0] w_dec_hit;

    always_comb begin
        w_inc_hit = '0;
        w_dec_hit = '0;
        for (int r = 0; r < NREGS; r++) begin
            w_inc_hit[r] = i_inc && (i_inc_addr == REG_AW'(r));
            w_dec_hit[r] = i_dec && (i_dec_addr == REG_AW'(r));
        end
    end

    // An entry and a retirement of the same register in one cycle cancel out.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) r_cnt[r] <= '0;
        end else if (i_en) begin
            for (int r = 0; r < NREGS; r++) begin
                if (w_inc_hit[r] && !w_dec_hit[r])
                    r_cnt[r] <= r_cnt[r] + CNT_W'(1);
                else if (w_dec_hit[r] && !w_inc_hit[r])
                    r_cnt[r] <= r_cnt[r] - CNT_W'(1);
            end
        end
    end

    always_comb begin
        o_pending = '0;
        for (int r = 1; r < NREGS; r++) o_pending[r] = (r_cnt[r] != '0);
    end

endmodule

// File: rtl/wb_tag_pipe.sv
// Tracks destination tags through ID_EX / EX_MEM / MEM_WB, detects load-use hazards
// and keeps a pending-write vector for the register file.
module wb_tag_pipe
    import wb_tag_pkg::*;
#(
    parameter int REG_AW = wb_tag_pkg::REG_AW,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              id_valid,
    input  logic              id_regwr,
    input  logic              id_memread,
    input  logic [REG_AW-1:0] id_dst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              id_flush,
    output logic              ID_EX_RegWr,
    output logic              EX_MEM_RegWr,
    output logic              MEM_WB_RegWr,
    output logic [REG_AW-1:0] ID_EX_Rd,
    output logic [REG_AW-1:0] EX_MEM_RegDst,
    output logic [REG_AW-1:0] MEM_WB_RegDst,
    output logic              ID_EX_MemRead,
    output logic              load_use_stall,
    output logic [31:0]       pending
);

    tag_t r_id_ex;
    tag_t r_ex_mem;
    tag_t r_mem_wb;
    tag_t w_issue;
    logic w_stall;
    logic w_dst_zero;

    assign w_dst_zero = (id_dst == '0);

    // Load in EX whose result the ID instruction needs: one bubble buys the cycle.
    assign w_stall = id_valid && r_id_ex.memread && (r_id_ex.dst != '0) &&
                     ((r_id_ex.dst == id_rs) || (id_uses_rt && (r_id_ex.dst == id_rt)));

    always_comb begin
        w_issue = BUBBLE_TAG;
        if (id_valid && !id_flush && !w_stall) begin
            w_issue.regwr   = id_regwr && !w_dst_zero;
            w_issue.memread = id_memread;
            w_issue.dst     = id_dst;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_id_ex  <= BUBBLE_TAG;
            r_ex_mem <= BUBBLE_TAG;
            r_mem_wb <= BUBBLE_TAG;
        end else if (!hold) begin
            r_id_ex  <= w_issue;
            r_ex_mem <= r_id_ex;
            r_mem_wb <= r_ex_mem;
        end
    end

    reg_pending_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_en       (!hold),
        .i_inc      (w_issue.regwr),
        .i_inc_addr (w_issue.dst),
        .i_dec      (r_mem_wb.regwr),
        .i_dec_addr (r_mem_wb.dst),
        .o_pending  (pending)
    );

    assign ID_EX_RegWr    = r_id_ex.regwr;
    assign EX_MEM_RegWr   = r_ex_mem.regwr;
    assign MEM_WB_RegWr   = r_mem_wb.regwr;
    assign ID_EX_Rd       = r_id_ex.dst;
    assign EX_MEM_RegDst  = r_ex_mem.dst;
    assign MEM_WB_RegDst  = r_mem_wb.dst;
    assign ID_EX_MemRead  = r_id_ex.memread;
    assign load_use_stall = w_stall;

endmodule

// File: tb/tb_wb_tag_pipe.sv
// Bench for wb_tag_pipe: directed scenarios plus a randomized run against an in-flight list model.
module tb_wb_tag_pipe;

    logic       clk = 1'b0;
    logic       reset, hold, id_valid, id_regwr, id_memread, id_flush, id_uses_rt;
    logic [4:0] id_dst, id_rs, id_rt;
    logic       ID_EX_RegWr, EX_MEM_RegWr, MEM_WB_RegWr, ID_EX_MemRead, load_use_stall;
    logic [4:0] ID_EX_Rd, EX_MEM_RegDst, MEM_WB_RegDst;
    logic [31:0] pending;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_tag_pipe dut (
        .clk(clk), .reset(reset), .hold(hold), .id_valid(id_valid), .id_regwr(id_regwr),
        .id_memread(id_memread), .id_dst(id_dst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_flush(id_flush),
        .ID_EX_RegWr(ID_EX_RegWr), .EX_MEM_RegWr(EX_MEM_RegWr), .MEM_WB_RegWr(MEM_WB_RegWr),
        .ID_EX_Rd(ID_EX_Rd), .EX_MEM_RegDst(EX_MEM_RegDst), .MEM_WB_RegDst(MEM_WB_RegDst),
        .ID_EX_MemRead(ID_EX_MemRead), .load_use_stall(load_use_stall), .pending(pending)
    );

    // Model: list of instructions in flight, youngest first; position = stages travelled.
    typedef struct {
        logic       regwr;
        logic       memread;
        logic [4:0] dst;
    } mtag_t;

    mtag_t m_q[$];

    function automatic mtag_t m_stage(input int k);
        mtag_t t;
        t.regwr = 1'b0; t.memread = 1'b0; t.dst = 5'd0;
        if (k < m_q.size()) t = m_q[k];
        return t;
    endfunction

    function automatic logic m_stall();
        mtag_t t;
        t = m_stage(0);
        return id_valid && t.memread && (t.dst != 5'd0) &&
               ((t.dst == id_rs) || (id_uses_rt && (t.dst == id_rt)));
    endfunction

    function automatic int m_count(input int r);
        int n = 0;
        foreach (m_q[i]) if (m_q[i].regwr && (m_q[i].dst == 5'(r))) n++;
        return n;
    endfunction

    function automatic logic [31:0] m_pending();
        logic [31:0] p = '0;
        for (int r = 1; r < 32; r++) p[r] = (m_count(r) != 0);
        return p;
    endfunction

    task automatic idle_inputs();
        reset = 1'b0; hold = 1'b0; id_valid = 1'b0; id_regwr = 1'b0; id_memread = 1'b0;
        id_flush = 1'b0; id_uses_rt = 1'b0; id_dst = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    endtask

    task automatic set_instr(input logic rw, input logic mr, input logic [4:0] d,
                             input logic [4:0] rs, input logic [4:0] rt, input logic urt);
        id_valid = 1'b1; id_regwr = rw; id_memread = mr; id_dst = d;
        id_rs = rs; id_rt = rt; id_uses_rt = urt;
    endtask

    // One clock edge; the model advances on the same inputs the DUT sees.
    task automatic tick();
        logic  s;
        mtag_t t;
        s = m_stall();
        @(posedge clk);
        if (reset) begin
            m_q.delete();
        end else if (!hold) begin
            t.regwr = 1'b0; t.memread = 1'b0; t.dst = 5'd0;
            if (id_valid && !id_flush && !s) begin
                t.regwr   = id_regwr && (id_dst != 5'd0);
                t.memread = id_memread;
                t.dst     = id_dst;
            end
            m_q.push_front(t);
            if (m_q.size() > 3) void'(m_q.pop_back());
        end
        #1;
    endtask

    task automatic drain();
        idle_inputs();
        repeat (4) tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        n_checks++;
        if ({ID_EX_RegWr, EX_MEM_RegWr, MEM_WB_RegWr, ID_EX_MemRead} !== 4'b0 ||
            {ID_EX_Rd, EX_MEM_RegDst, MEM_WB_RegDst} !== 15'd0) begin
            n_errors++;
            $display("FAIL reset_tags: got wr=%b%b%b mr=%b dst=%0d/%0d/%0d expected all 0",
                     ID_EX_RegWr, EX_MEM_RegWr, MEM_WB_RegWr, ID_EX_MemRead,
                     ID_EX_Rd, EX_MEM_RegDst, MEM_WB_RegDst);
        end
        n_checks++;
        if (pending !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_pending: got %h expected 0", pending);
        end
    endtask

    task automatic test_latency();
        idle_inputs();
        set_instr(1'b1, 1'b0, 5'd8, 5'd1, 5'd2, 1'b1);
        tick();
        idle_inputs();
        n_checks++;
        if (ID_EX_Rd !== 5'd8 || ID_EX_RegWr !== 1'b1 || pending[8] !== 1'b1) begin
            n_errors++;
            $display("FAIL lat_id_ex: got rd=%0d wr=%b p8=%b expected 8 1 1", ID_EX_Rd, ID_EX_RegWr, pending[8]);
        end
        tick();
        n_checks++;
        if (EX_MEM_RegDst !== 5'd8 || EX_MEM_RegWr !== 1'b1) begin
            n_errors++;
            $display("FAIL lat_ex_mem: got rd=%0d wr=%b expected 8 1", EX_MEM_RegDst, EX_MEM_RegWr);
        end
        tick();
        n_checks++;
        if (MEM_WB_RegDst !== 5'd8 || MEM_WB_RegWr !== 1'b1 || pending[8] !== 1'b1) begin
            n_errors++;
            $display("FAIL lat_mem_wb: got rd=%0d wr=%b p8=%b expected 8 1 1", MEM_WB_RegDst, MEM_WB_RegWr, pending[8]);
        end
        tick();
        n_checks++;
        if (pending !== 32'd0) begin
            n_errors++;
            $display("FAIL lat_retire: got pending=%h expected 0", pending);
        end
    endtask

    task automatic test_load_use(input logic flush);
        idle_inputs();
        set_instr(1'b1, 1'b1, 5'd9, 5'd3, 5'd4, 1'b0);
        tick();
        set_instr(1'b1, 1'b0, 5'd10, 5'd9, 5'd0, 1'b1);
        id_flush = flush;
        #1;
        n_checks++;
        if (load_use_stall !== 1'b1) begin
            n_errors++;
            $display("FAIL lu_stall_on(flush=%b): got %b expected 1", flush, load_use_stall);
        end
        tick();
        n_checks++;
        if (ID_EX_RegWr !== 1'b0 || ID_EX_MemRead !== 1'b0 || EX_MEM_RegDst !== 5'd9) begin
            n_errors++;
            $display("FAIL lu_bubble(flush=%b): got wr=%b mr=%b exmem=%0d expected 0 0 9",
                     flush, ID_EX_RegWr, ID_EX_MemRead, EX_MEM_RegDst);
        end
        id_flush = 1'b0;
        #1;
        n_checks++;
        if (load_use_stall !== 1'b0) begin
            n_errors++;
            $display("FAIL lu_stall_off(flush=%b): got %b expected 0", flush, load_use_stall);
        end
        tick();
        n_checks++;
        if (ID_EX_Rd !== 5'd10 || ID_EX_RegWr !== 1'b1) begin
            n_errors++;
            $display("FAIL lu_reissue(flush=%b): got rd=%0d wr=%b expected 10 1", flush, ID_EX_Rd, ID_EX_RegWr);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        set_instr(1'b1, 1'b0, 5'd5, 5'd1, 5'd1, 1'b0);
        repeat (3) tick();
        idle_inputs();
        n_checks++;
        if (dut.u_cnt.r_cnt[5] !== 2'd3 || pending[5] !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_full: got cnt5=%0d p5=%b expected 3 1", dut.u_cnt.r_cnt[5], pending[5]);
        end
        repeat (2) tick();
        n_checks++;
        if (pending[5] !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_partial: got p5=%b expected 1", pending[5]);
        end
        tick();
        n_checks++;
        if (pending[5] !== 1'b0 || dut.u_cnt.r_cnt[5] !== 2'd0) begin
            n_errors++;
            $display("FAIL b2b_drain: got cnt5=%0d p5=%b expected 0 0", dut.u_cnt.r_cnt[5], pending[5]);
        end
    endtask

    task automatic test_dst_zero();
        idle_inputs();
        set_instr(1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1);
        tick();
        idle_inputs();
        n_checks++;
        if (ID_EX_RegWr !== 1'b0 || ID_EX_Rd !== 5'd0 || pending !== 32'd0) begin
            n_errors++;
            $display("FAIL dst_zero: got wr=%b rd=%0d pending=%h expected 0 0 0", ID_EX_RegWr, ID_EX_Rd, pending);
        end
        drain();
    endtask

    task automatic test_hold();
        idle_inputs();
        set_instr(1'b1, 1'b1, 5'd9, 5'd3, 5'd4, 1'b0);
        tick();
        set_instr(1'b1, 1'b0, 5'd11, 5'd9, 5'd0, 1'b0);
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (ID_EX_Rd !== 5'd9 || ID_EX_MemRead !== 1'b1 || load_use_stall !== 1'b1 ||
                EX_MEM_RegWr !== 1'b0 || pending !== (32'd1 << 9)) begin
                n_errors++;
                $display("FAIL hold_frozen[%0d]: got rd=%0d mr=%b stall=%b exwr=%b pending=%h expected 9 1 1 0 %h",
                         i, ID_EX_Rd, ID_EX_MemRead, load_use_stall, EX_MEM_RegWr, pending, 32'd1 << 9);
            end
        end
        hold = 1'b0;
        tick();
        n_checks++;
        if (ID_EX_RegWr !== 1'b0 || EX_MEM_RegDst !== 5'd9 || EX_MEM_RegWr !== 1'b1) begin
            n_errors++;
            $display("FAIL hold_resume: got idwr=%b exmem=%0d exwr=%b expected 0 9 1", ID_EX_RegWr, EX_MEM_RegDst, EX_MEM_RegWr);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        set_instr(1'b1, 1'b0, 5'd5, 5'd1, 5'd1, 1'b0);
        tick();
        set_instr(1'b1, 1'b1, 5'd9, 5'd1, 5'd1, 1'b0);
        tick();
        idle_inputs();
        reset = 1'b1;
        hold = 1'b1;
        tick();
        reset = 1'b0;
        hold = 1'b0;
        n_checks++;
        if (pending !== 32'd0 || {ID_EX_RegWr, EX_MEM_RegWr, MEM_WB_RegWr, ID_EX_MemRead} !== 4'b0 ||
            {ID_EX_Rd, EX_MEM_RegDst, MEM_WB_RegDst} !== 15'd0) begin
            n_errors++;
            $display("FAIL reset_mid: got pending=%h wr=%b%b%b dst=%0d/%0d/%0d expected all 0",
                     pending, ID_EX_RegWr, EX_MEM_RegWr, MEM_WB_RegWr, ID_EX_Rd, EX_MEM_RegDst, MEM_WB_RegDst);
        end
        tick();
        n_checks++;
        if (pending !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_mid_hold: got pending=%h expected 0", pending);
        end
    endtask

    task automatic test_random();
        mtag_t s0, s1, s2;
        for (int cyc = 0; cyc < 400; cyc++) begin
            reset      = ($urandom_range(63) == 0);
            hold       = ($urandom_range(7) == 0);
            id_flush   = ($urandom_range(7) == 0);
            id_valid   = ($urandom_range(5) != 0);
            id_regwr   = ($urandom_range(3) != 0);
            id_memread = ($urandom_range(2) == 0);
            id_uses_rt = $urandom_range(1);
            id_dst     = 5'($urandom_range(7));
            id_rs      = 5'($urandom_range(7));
            id_rt      = 5'($urandom_range(7));
            #1;
            n_checks++;
            if (load_use_stall !== m_stall()) begin
                n_errors++;
                $display("FAIL rnd_stall[%0d]: got %b expected %b", cyc, load_use_stall, m_stall());
            end
            tick();
            s0 = m_stage(0); s1 = m_stage(1); s2 = m_stage(2);
            n_checks++;
            if (ID_EX_RegWr !== s0.regwr || ID_EX_MemRead !== s0.memread || ID_EX_Rd !== s0.dst ||
                EX_MEM_RegWr !== s1.regwr || EX_MEM_RegDst !== s1.dst ||
                MEM_WB_RegWr !== s2.regwr || MEM_WB_RegDst !== s2.dst) begin
                n_errors++;
                $display("FAIL rnd_tags[%0d]: got %b%b%0d %b%0d %b%0d expected %b%b%0d %b%0d %b%0d", cyc,
                         ID_EX_RegWr, ID_EX_MemRead, ID_EX_Rd, EX_MEM_RegWr, EX_MEM_RegDst, MEM_WB_RegWr, MEM_WB_RegDst,
                         s0.regwr, s0.memread, s0.dst, s1.regwr, s1.dst, s2.regwr, s2.dst);
            end
            n_checks++;
            if (pending !== m_pending()) begin
                n_errors++;
                $display("FAIL rnd_pending[%0d]: got %h expected %h", cyc, pending, m_pending());
            end
            for (int r = 0; r < 8; r++) begin
                if (dut.u_cnt.r_cnt[r] > 2'd3 || int'(dut.u_cnt.r_cnt[r]) != m_count(r)) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rnd_cnt[%0d] r%0d: got %0d expected %0d", cyc, r, dut.u_cnt.r_cnt[r], m_count(r));
                end
            end
        end
        reset = 1'b0;
        drain();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_latency();
        test_load_use(1'b0);
        test_load_use(1'b1);
        test_back_to_back();
        test_dst_zero();
        test_hold();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
